// File: rtl/spectrum_packetizer.sv
// spectrum_packetizer
// Packs 16-bit complex samples from the requantizer into 64-bit words, four
// channels per word, and prefixes every spectrum with a header word carrying
// a spectrum counter. Frames are buffered in a first-word-fall-through FIFO
// and leave on a valid/ready stream toward the 10GbE framer. A spectrum is
// admitted only if the FIFO can hold the whole frame; otherwise it is dropped
// in its entirety.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ce              input sample valid
//   data_in[15:0]   complex sample {re[15:8], im[7:0]}
//   sync_in         marks the channel-0 sample of a spectrum (with ce)
//   m_tdata[63:0]   output word
//   m_tvalid        output word valid
//   m_tlast         last word of a frame
//   m_tready        downstream ready
//   drop_count      spectra dropped for lack of FIFO room (saturating)
//   sync_err_count  syncs seen mid-frame (saturating)
//   spec_count      syncs accepted at frame boundaries, dropped or not

module spectrum_packetizer #(
    parameter int CHANNELS   = 2048,
    parameter int FIFO_DEPTH = 2048,
    parameter int CNT_WIDTH  = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [15:0]          data_in,
    input  logic                 sync_in,
    output logic [63:0]          m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [31:0]          drop_count,
    output logic [31:0]          sync_err_count,
    output logic [CNT_WIDTH-1:0] spec_count
);

    localparam int W  = CHANNELS / 4;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CHANNELS);

    typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;

    state_t state, state_next;

    logic [CW-1:0] ch_cnt;
    logic [1:0]    lane;
    logic [47:0]   pack;

    logic [64:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW:0]   used;
    logic [AW:0]   free_words;
    logic          empty;
    logic          pop;
    logic          push;
    logic [64:0]   push_word;
    logic [64:0]   rd_word;

    logic          sync_ce;
    logic          room;
    logic          last_sample;

    assign lane        = ch_cnt[1:0];
    assign sync_ce     = ce & sync_in;
    assign last_sample = ce && (ch_cnt == CW'(CHANNELS - 1));

    // Occupancy uses pointers one bit wider than the address so that full and
    // empty are distinguishable. A pop on the sync cycle counts as free room.
    assign used       = wr_ptr - rd_ptr;
    assign empty      = (used == '0);
    assign pop        = !empty && m_tready;
    assign free_words = (AW+1)'(FIFO_DEPTH) - used + {{AW{1'b0}}, pop};
    assign room       = (free_words >= (AW+1)'(W + 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a frame always runs for exactly CHANNELS samples,
    // whether captured or dropped, so a stray sync cannot resync mid-frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sync_ce) begin
                    state_next = room ? CAPTURE : DROP;
                end
            end
            CAPTURE, DROP: begin
                if (last_sample) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: FIFO writes. The header goes in on the sync cycle and a
    // payload word goes in when lane 3 arrives, so the two never collide.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        case (state)
            IDLE: begin
                if (sync_ce && room) begin
                    push      = 1'b1;
                    push_word = {1'b0, 8'hA5, 8'h00, 48'(spec_count)};
                end
            end
            CAPTURE: begin
                if (ce && lane == 2'd3) begin
                    push      = 1'b1;
                    push_word = {last_sample, data_in, pack};
                end
            end
            default: ;
        endcase
    end

    // Channel counter and lane holding register. The counter wraps to zero
    // naturally after channel CHANNELS-1 because CHANNELS is a power of two.
    // Lanes 0..2 are held until lane 3 completes the word; writes while idle
    // are harmless because an accepted sync overwrites lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt <= '0;
            pack   <= '0;
        end else if (ce) begin
            if (state != IDLE || sync_in) begin
                ch_cnt <= ch_cnt + 1'b1;
            end
            case (lane)
                2'd0:    pack[15:0]  <= data_in;
                2'd1:    pack[31:16] <= data_in;
                2'd2:    pack[47:32] <= data_in;
                default: ;
            endcase
        end
    end

    // Statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_count     <= '0;
            drop_count     <= '0;
            sync_err_count <= '0;
        end else begin
            if (state == IDLE && sync_ce) begin
                spec_count <= spec_count + 1'b1;
                if (!room && drop_count != 32'hFFFF_FFFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
            if (state != IDLE && sync_ce && sync_err_count != 32'hFFFF_FFFF) begin
                sync_err_count <= sync_err_count + 1'b1;
            end
        end
    end

    // FIFO pointers; reset flushes any buffered or partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage, bit 64 carries tlast
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
        end
    end

    // First-word-fall-through read: head word is visible whenever non-empty
    assign rd_word  = mem[rd_ptr[AW-1:0]];
    assign m_tvalid = !empty;
    assign m_tdata  = empty ? 64'd0 : rd_word[63:0];
    assign m_tlast  = empty ? 1'b0  : rd_word[64];

endmodule

// File: tb/tb_spectrum_packetizer.sv
// tb_spectrum_packetizer
// Directed bench for spectrum_packetizer with CHANNELS=16, FIFO_DEPTH=16,
// so each frame is one header plus four payload words.

module tb_spectrum_packetizer;

    localparam int CHANNELS   = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_WIDTH  = 48;
    localparam int FRAME      = CHANNELS / 4 + 1;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 ce = 1'b0;
    logic [15:0]          data_in = '0;
    logic                 sync_in = 1'b0;
    logic [63:0]          m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready = 1'b1;
    logic [31:0]          drop_count;
    logic [31:0]          sync_err_count;
    logic [CNT_WIDTH-1:0] spec_count;

    int          total = 0;
    int          bad = 0;
    logic [64:0] got[$];
    logic [64:0] held;
    bit          hold_pending = 0;
    bit          rand_ready = 0;

    spectrum_packetizer #(
        .CHANNELS(CHANNELS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .data_in(data_in),
        .sync_in(sync_in),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tlast(m_tlast),
        .m_tready(m_tready),
        .drop_count(drop_count),
        .sync_err_count(sync_err_count),
        .spec_count(spec_count)
    );

    always #5 clk = ~clk;

    // Output monitor on the falling edge: records every accepted word and
    // checks that a stalled word does not change until it is taken.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 0;
        end else begin
            if (hold_pending && m_tvalid) begin
                total++;
                if ({m_tlast, m_tdata} !== held) begin
                    bad++;
                    $display("[TB] FAIL hold_stable: got %h required %h", {m_tlast, m_tdata}, held);
                end
            end
            if (m_tvalid && m_tready) begin
                got.push_back({m_tlast, m_tdata});
                hold_pending = 0;
            end else if (m_tvalid) begin
                held = {m_tlast, m_tdata};
                hold_pending = 1;
            end else begin
                hold_pending = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        if (rand_ready) m_tready = ($urandom_range(0, 99) < 30);
    endtask

    task automatic applyStimulus(input logic sync, input logic [15:0] data);
        ce = 1'b1;
        sync_in = sync;
        data_in = data;
        nextCycle();
        ce = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic sendSpectrum(input logic [15:0] base, input bit gaps);
        for (int c = 0; c < CHANNELS; c++) begin
            applyStimulus(c == 0, base + 16'(c));
            if (gaps) nextCycle();
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        ce = 1'b0;
        sync_in = 1'b0;
        rand_ready = 0;
        m_tready = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        got.delete();
    endtask

    task automatic waitWords(input string name, input int n);
        int cycles = 0;
        while (got.size() < n && cycles < 1000) begin
            nextCycle();
            cycles++;
        end
        checkOutput({name, "_count"}, 65'(got.size() >= n ? n : got.size()), 65'(n));
    endtask

    function automatic logic [64:0] gotWord(input int idx);
        if (idx < got.size()) return got[idx];
        return 'x;
    endfunction

    // Reference word k of a frame whose samples are base+c on channel c
    function automatic logic [64:0] expWord(input int k, input logic [47:0] hdr, input logic [15:0] base);
        logic [63:0] w;
        if (k == 0) return {1'b0, 8'hA5, 8'h00, hdr};
        for (int i = 0; i < 4; i++) w[16*i +: 16] = base + 16'(4*(k-1) + i);
        return {(k == FRAME - 1), w};
    endfunction

    task automatic checkFrame(input string name, input int start, input logic [47:0] hdr, input logic [15:0] base);
        for (int k = 0; k < FRAME; k++) begin
            checkOutput($sformatf("%s_w%0d", name, k), gotWord(start + k), expWord(k, hdr, base));
        end
    endtask

    initial begin
        vec_t tbl[FRAME];
        tbl[0] = '{64'hA500000000000000, 1'b0};
        tbl[1] = '{64'h0003000200010000, 1'b0};
        tbl[2] = '{64'h0007000600050004, 1'b0};
        tbl[3] = '{64'h000B000A00090008, 1'b0};
        tbl[4] = '{64'h000F000E000D000C, 1'b1};

        resetDut();
        checkOutput("reset_tvalid", 65'(m_tvalid), 65'd0);
        checkOutput("reset_tdata", 65'(m_tdata), 65'd0);
        checkOutput("reset_counters", {drop_count, sync_err_count, 1'b0}, 65'd0);
        checkOutput("reset_spec", 65'(spec_count), 65'd0);

        // Contiguous spectrum, header visible one cycle after the sync
        applyStimulus(1'b1, 16'h0000);
        checkOutput("fwft_valid", 65'(m_tvalid), 65'd1);
        for (int c = 1; c < CHANNELS; c++) applyStimulus(1'b0, 16'(c));
        waitWords("t1", FRAME);
        for (int i = 0; i < FRAME; i++)
            checkOutput($sformatf("t1_w%0d", i), gotWord(i), {tbl[i].last, tbl[i].data});
        checkOutput("t1_spec", 65'(spec_count), 65'd1);

        // Same spectrum with ce toggling
        resetDut();
        sendSpectrum(16'h0000, 1);
        repeat (10) nextCycle();
        checkOutput("t2_size", 65'(got.size()), 65'(FRAME));
        for (int i = 0; i < FRAME; i++)
            checkOutput($sformatf("t2_w%0d", i), gotWord(i), {tbl[i].last, tbl[i].data});

        // Back-pressure: three frames fit, the fourth is dropped
        resetDut();
        m_tready = 1'b0;
        for (int s = 0; s < 4; s++) sendSpectrum(16'(s * 256), 0);
        checkOutput("t3_drop", 65'(drop_count), 65'd1);
        checkOutput("t3_spec", 65'(spec_count), 65'd4);
        checkOutput("t3_none_out", 65'(got.size()), 65'd0);
        m_tready = 1'b1;
        waitWords("t3", 3 * FRAME);
        repeat (10) nextCycle();
        checkOutput("t3_size", 65'(got.size()), 65'(3 * FRAME));
        for (int s = 0; s < 3; s++)
            checkFrame($sformatf("t3_f%0d", s), s * FRAME, 48'(s), 16'(s * 256));

        // Misplaced sync at channel 5, then a normal spectrum
        resetDut();
        for (int c = 0; c < CHANNELS; c++) applyStimulus(c == 0 || c == 5, 16'h0100 + 16'(c));
        sendSpectrum(16'h0200, 0);
        waitWords("t4", 2 * FRAME);
        checkOutput("t4_syncerr", 65'(sync_err_count), 65'd1);
        checkOutput("t4_spec", 65'(spec_count), 65'd2);
        checkFrame("t4_f0", 0, 48'd0, 16'h0100);
        checkFrame("t4_f1", FRAME, 48'd1, 16'h0200);

        // Samples with no sync are discarded
        resetDut();
        for (int c = 0; c < 10; c++) applyStimulus(1'b0, 16'h0300 + 16'(c));
        nextCycle();
        checkOutput("t5_idle_valid", 65'(m_tvalid), 65'd0);
        checkOutput("t5_idle_spec", 65'(spec_count), 65'd0);
        sendSpectrum(16'h0400, 0);
        waitWords("t5", FRAME);
        checkFrame("t5_f0", 0, 48'd0, 16'h0400);

        // Random 30% ready: sequence unchanged, monitor checks stalls
        resetDut();
        rand_ready = 1;
        sendSpectrum(16'h0500, 0);
        sendSpectrum(16'h0600, 0);
        waitWords("t6", 2 * FRAME);
        rand_ready = 0;
        m_tready = 1'b1;
        checkOutput("t6_drop", 65'(drop_count), 65'd0);
        checkFrame("t6_f0", 0, 48'd0, 16'h0500);
        checkFrame("t6_f1", FRAME, 48'd1, 16'h0600);

        // Reset in the middle of a frame with words buffered
        resetDut();
        m_tready = 1'b0;
        sendSpectrum(16'h0700, 0);
        for (int c = 0; c < 7; c++) applyStimulus(c == 0 || c == 3, 16'h0800 + 16'(c));
        checkOutput("t7_pre_valid", 65'(m_tvalid), 65'd1);
        checkOutput("t7_pre_syncerr", 65'(sync_err_count), 65'd1);
        rst = 1'b1;
        nextCycle();
        checkOutput("t7_valid", 65'(m_tvalid), 65'd0);
        checkOutput("t7_counters", {drop_count, sync_err_count, 1'b0}, 65'd0);
        checkOutput("t7_spec", 65'(spec_count), 65'd0);
        rst = 1'b0;
        got.delete();
        m_tready = 1'b1;
        sendSpectrum(16'h0900, 0);
        waitWords("t7", FRAME);
        repeat (10) nextCycle();
        checkOutput("t7_size", 65'(got.size()), 65'(FRAME));
        checkFrame("t7_f0", 0, 48'd0, 16'h0900);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spectrum_packetizer.md
Name: spectrum_packetizer

Overview:
- Sits directly downstream of the requantizer. Consumes its 8+8-bit complex samples, one per channel, with a sync marking channel 0.
- Packs four samples into each 64-bit word and prefixes each spectrum with a header word carrying a spectrum counter.
- Buffers frames in a FIFO and emits them on a valid/ready stream toward the 10GbE framer.
- Drops whole spectra, never partial ones, when the FIFO cannot hold a complete frame; dropped spectra and sync errors are counted.

Parameters:
- CHANNELS, 2048, channels per spectrum; power of two, >= 4.
- FIFO_DEPTH, 2048, FIFO depth in 64-bit words; power of two, >= CHANNELS/4+1.
- CNT_WIDTH, 48, spectrum counter width; <= 48.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ce  in  1  input sample valid (clock enable)
- data_in  in  16  complex sample {re[15:8], im[7:0]}, signed 8-bit each
- sync_in  in  1  high with ce on the channel-0 sample of a spectrum
- m_tdata  out  64  output word
- m_tvalid  out  1  output word valid
- m_tlast  out  1  last word of a frame
- m_tready  in  1  downstream ready
- drop_count  out  32  spectra dropped; saturating
- sync_err_count  out  32  misplaced syncs; saturating
- spec_count  out  CNT_WIDTH  syncs accepted at frame boundaries, dropped or not

Behaviour:
- Derived widths: W = CHANNELS/4 payload words per spectrum; frame length = W+1 words.
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, all counters 0, FIFO empty, FSM=IDLE, channel counter=0.
- A sample is consumed only on cycles with ce=1; ce=0 cycles are ignored entirely.
- FSM states: IDLE, CAPTURE, DROP.
- IDLE, ce & sync_in, FIFO free words >= W+1:
  - Write header {8'hA5, 8'h00, zero-extended spec_count} into the FIFO that cycle.
  - The sample is also lane 0 of the first payload word.
  - spec_count increments; go to CAPTURE.
- IDLE, ce & sync_in, FIFO free words < W+1:
  - drop_count increments (saturates at 2^32-1); spec_count increments; go to DROP.
- IDLE, ce & !sync_in: sample discarded; no counter changes.
- Packing: channel c goes to lane c%4 at bits [16*(c%4)+15 : 16*(c%4)]. The word is written to the FIFO on the cycle lane 3 is consumed.
- CAPTURE and DROP each consume exactly CHANNELS samples, channel 0 included, then return to IDLE.
  - The last sample returns to IDLE on the following cycle. A sync on the next ce sample is accepted.
  - DROP writes nothing to the FIFO.
- sync_in with ce in CAPTURE/DROP at channel != 0: sync_err_count increments (saturating); the sample is treated as ordinary data. No resync occurs mid-frame.
- spec_count wraps modulo 2^CNT_WIDTH.
- FIFO is first-word-fall-through:
  - A word written at cycle N into an empty FIFO shows m_tvalid=1 at N+1.
  - One word is popped per cycle with m_tvalid & m_tready.
  - m_tdata and m_tlast are held stable while m_tvalid & !m_tready.
- m_tlast is high on payload word W only. It is stored as a 65th FIFO bit.
- Because of the admission check the FIFO never overflows. Simultaneous push and pop at full or empty is legal.
- Free-word count is evaluated combinationally at the sync cycle and includes a pop on that same cycle.
- rst mid-frame: FIFO flushed, partial frame lost, m_tvalid=0 next cycle.
- Throughput: one sample per cycle sustained, W+1 words per CHANNELS cycles output.

Test Plan:
- CHANNELS=16, FIFO_DEPTH=16, m_tready=1; sync then samples 16'h0000..16'h000F contiguous.
  - Expect 5 words: A5000000_00000000, 0003000200010000, 0007000600050004, 000B000A00090008, 000F000E000D000C.
  - tlast on the 5th word; spec_count=1.
- Same setup, ce toggling 1/0 every cycle.
  - Identical 5-word output; no extra writes during ce=0 cycles.
- m_tready=0, 4 back-to-back spectra.
  - 3 frames fit (15 words); 4th dropped: drop_count=1, spec_count=4.
  - Release ready: 3 frames with headers counting 0,1,2 and tlast each.
- sync_in asserted at channel 5 inside a capture.
  - sync_err_count=1; frame still 5 words with sample 5 in place; next valid sync is accepted normally.
- Samples with no preceding sync, then sync.
  - Nothing emitted before sync; first header count = 0.
- m_tready random 30% during output.
  - Word sequence unchanged; m_tdata stable whenever valid & !ready.
- rst asserted mid-frame.
  - Next cycle: m_tvalid=0, all counters 0; subsequent spectrum emits header count 0.
